alu_seq_exec: RTL and testbench

- Execute-stage ALU sitting directly downstream of the ALU control decoder. It consumes the 4-bit Operation code plus two register-file/immediate operands and produces a registered result and zero flag.
- Single-cycle ops (AND, OR, ADD, SUB) complete in one clock.
- Left shift (SLL/SLLI) is iterative, one bit per clock, so the datapath needs no barrel shifter.
- Valid/ready handshakes on both input and output allow the pipeline to stall around multi-cycle shifts.

---
 rtl/alu_seq_exec.sv | 111 +++++++++++
 tb/tb_alu_seq_exec.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/alu_seq_exec.sv
// Execute-stage ALU with registered result/zero and valid/ready handshakes.
// AND/OR/ADD/SUB finish in one edge; SLL shifts one bit per clock.
module alu_seq_exec #(
   parameter int WIDTH   = 64,
   parameter int SHAMT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       Operation,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero
);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLL = 4'b1111;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     acc_q, acc_d;
   logic [SHAMT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]     result_q, result_d;
   logic                 zero_q, zero_d;

   logic [SHAMT_W-1:0]   shamt;
   logic [WIDTH-1:0]     alu_val;
   logic [WIDTH-1:0]     shifted;

   assign shamt   = b[SHAMT_W-1:0];
   assign shifted = acc_q << 1;

   // SLL only reaches this path with shamt == 0, so it simply passes a through.
   always_comb begin
      alu_val = '0;
      case (Operation)
         OP_AND:  alu_val = a & b;
         OP_OR:   alu_val = a | b;
         OP_ADD:  alu_val = a + b;
         OP_SUB:  alu_val = a - b;
         OP_SLL:  alu_val = a;
         default: alu_val = '0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      zero_d   = zero_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               if (Operation == OP_SLL && shamt != '0) begin
                  acc_d   = a;
                  cnt_d   = shamt;
                  state_d = S_SHIFT;
               end else begin
                  result_d = alu_val;
                  zero_d   = ~|alu_val;
                  state_d  = S_DONE;
               end
            end
         end
         S_SHIFT: begin
            acc_d = shifted;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == SHAMT_W'(1)) begin
               result_d = shifted;
               zero_d   = ~|shifted;
               state_d  = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         acc_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         zero_q   <= zero_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign result    = result_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
// Self-checking bench for alu_seq_exec: directed cases, then random ops vs. a reference model.
module tb_alu_seq_exec;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  op_i;
   logic [63:0] a_i;
   logic [63:0] b_i;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] result;
   logic        zero;

   int total = 0;
   int bad   = 0;

   alu_seq_exec #(.WIDTH(64), .SHAMT_W(6)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .Operation (op_i),
      .a         (a_i),
      .b         (b_i),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] ref_model(input logic [3:0] op, input logic [63:0] x,
                                             input logic [63:0] y);
      case (op)
         4'b0000: return x & y;
         4'b0001: return x | y;
         4'b0010: return x + y;
         4'b0110: return x - y;
         4'b1111: return x << y[5:0];
         default: return 64'd0;
      endcase
   endfunction

   function automatic int ref_latency(input logic [3:0] op, input logic [63:0] y);
      if (op == 4'b1111 && y[5:0] != 6'd0) return int'(y[5:0]) + 1;
      return 1;
   endfunction

   // Called at posedge+1 with the DUT idle; leaves the DUT idle at posedge+1.
   task automatic do_op(input logic [3:0] op, input logic [63:0] x, input logic [63:0] y,
                        input int bp_cycles);
      logic [63:0] exp_r;
      int          exp_lat;
      int          lat;
      exp_r   = ref_model(op, x, y);
      exp_lat = ref_latency(op, y);
      chk("in_ready_idle", {63'd0, in_ready}, 64'd1);
      in_valid = 1'b1; op_i = op; a_i = x; b_i = y;
      @(posedge clk); #1;
      // Scramble inputs after acceptance: they must be ignored.
      in_valid = 1'b0; op_i = 4'($urandom); a_i = {$urandom, $urandom}; b_i = {$urandom, $urandom};
      lat = 1;
      while (!out_valid && lat < 200) begin
         chk("in_ready_busy", {63'd0, in_ready}, 64'd0);
         in_valid  = 1'($urandom);
         out_ready = 1'($urandom);
         @(posedge clk); #1;
         lat++;
      end
      out_ready = 1'b0;
      in_valid  = 1'b0;
      chk("latency", 64'(lat), 64'(exp_lat));
      chk("out_valid", {63'd0, out_valid}, 64'd1);
      chk("result", result, exp_r);
      chk("zero", {63'd0, zero}, {63'd0, exp_r == 64'd0});
      $display("op=%h a=%h b=%h -> result=%h zero=%b lat=%0d", op, x, y, result, zero, lat);
      for (int i = 0; i < bp_cycles; i++) begin
         in_valid = 1'($urandom);
         @(posedge clk); #1;
         chk("bp_valid", {63'd0, out_valid}, 64'd1);
         chk("bp_result", result, exp_r);
         chk("bp_zero", {63'd0, zero}, {63'd0, exp_r == 64'd0});
      end
      // Transfer edge with in_valid high: must not start a new op.
      out_ready = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b0;
      chk("post_valid", {63'd0, out_valid}, 64'd0);
      chk("post_ready", {63'd0, in_ready}, 64'd1);
      chk("post_result", result, exp_r);
   endtask

   initial begin
      logic [3:0]  rop;
      logic [63:0] ra, rb;
      reset = 1'b0; in_valid = 1'b0; op_i = 4'd0; a_i = '0; b_i = '0; out_ready = 1'b0;
      #2;
      chk("rst_result", result, 64'd0);
      chk("rst_zero", {63'd0, zero}, 64'd0);
      chk("rst_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_ready", {63'd0, in_ready}, 64'd1);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;

      do_op(4'b0010, 64'd5, 64'd7, 0);
      do_op(4'b0110, 64'd9, 64'd9, 0);
      do_op(4'b0110, 64'd0, 64'd1, 0);
      do_op(4'b0000, 64'hF0, 64'h3C, 0);
      do_op(4'b0001, 64'hF0, 64'h3C, 0);
      do_op(4'b1111, 64'd1, 64'd3, 0);
      do_op(4'b1111, 64'd1, 64'd66, 0);
      do_op(4'b1111, 64'd3, 64'd63, 0);
      do_op(4'b1111, 64'h1234_5678_9ABC_DEF0, 64'd0, 0);
      do_op(4'b0010, 64'd100, 64'd23, 5);
      do_op(4'b0101, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0);
      do_op(4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 0);

      // Reset in the middle of a long shift.
      in_valid = 1'b1; op_i = 4'b1111; a_i = 64'hDEAD_BEEF; b_i = 64'd40;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) begin @(posedge clk); #1; end
      chk("mid_shift_busy", {63'd0, in_ready}, 64'd0);
      reset = 1'b0;
      #1;
      chk("arst_valid", {63'd0, out_valid}, 64'd0);
      chk("arst_result", result, 64'd0);
      chk("arst_zero", {63'd0, zero}, 64'd0);
      chk("arst_ready", {63'd0, in_ready}, 64'd1);
      $display("async reset mid-shift: valid=%b result=%h zero=%b ready=%b",
               out_valid, result, zero, in_ready);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      do_op(4'b0010, 64'd2, 64'd2, 0);

      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 6))
            0: rop = 4'b0000;
            1: rop = 4'b0001;
            2: rop = 4'b0010;
            3: rop = 4'b0110;
            4, 5: rop = 4'b1111;
            default: rop = 4'($urandom_range(0, 15));
         endcase
         ra = {$urandom, $urandom};
         rb = ($urandom_range(0, 5) == 0) ? ra : {$urandom, $urandom};
         do_op(rop, ra, rb, int'($urandom_range(0, 3)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
